// File: rtl/powerup_pkg.sv
// Shared constants for the power-up timer bank: channel state encoding,
// the prescaler default for the 65 MHz board clock, and the default
// durations the game logic hands out for each power-up type.
package powerup_pkg;

  // Channel state encoding. A channel is either idle or counting down.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Board clock and the resulting one-second tick period (minus one).
  localparam int unsigned CLK_HZ        = 65_000_000;
  localparam int unsigned DEF_PRESCALER = CLK_HZ - 1;

  // Default power-up durations in ticks, used by the instantiating
  // game module to drive grant_time.
  localparam int unsigned PP1_TICKS = 3;
  localparam int unsigned PP2_TICKS = 2;
  localparam int unsigned PP3_TICKS = 5;
  localparam int unsigned PP4_TICKS = 4;

  // Smallest legal channel-index width for a given channel count.
  function automatic int unsigned ch_index_width(input int unsigned n);
    ch_index_width = (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/powerup_channel.sv
// One power-up countdown channel: IDLE/RUN state, remaining-time counter,
// optional saturating extension on re-grant, and a one-cycle expiry pulse.
// Priority inside the channel is clear > load > tick, so a load arriving
// on the same cycle as a tick suppresses that tick's decrement (and any
// expiry it would have caused).
module powerup_channel
  import powerup_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int EXTEND_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             clear,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_val,
  output logic [0:0]       state_dbg,
  output logic [CNT_W-1:0] remaining,
  output logic             expire_pulse
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [0:0]       state_q;
  logic [0:0]       state_n;
  logic [CNT_W-1:0] rem_n;
  logic             exp_n;
  logic [CNT_W:0]   sum_wide;
  logic [CNT_W-1:0] sum_sat;
  logic [CNT_W-1:0] load_next;

  // Saturating extension: add in CNT_W+1 bits, clamp to all-ones on carry.
  always_comb begin
    sum_wide = {1'b0, remaining} + {1'b0, load_val};
    sum_sat  = sum_wide[CNT_W] ? {CNT_W{1'b1}} : sum_wide[CNT_W-1:0];
    // In IDLE remaining is zero, so extension reduces to a plain load.
    load_next = (EXTEND_MODE != 0) ? sum_sat : load_val;
  end

  // Next-state logic for the channel FSM, counter and expiry pulse.
  always_comb begin
    state_n = state_q;
    rem_n   = remaining;
    exp_n   = 1'b0;
    if (clear) begin
      state_n = ST_IDLE;
      rem_n   = '0;
    end else if (load_en) begin
      state_n = ST_RUN;
      rem_n   = load_next;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (tick) begin
            if (remaining == CNT_ONE) begin
              state_n = ST_IDLE;
              rem_n   = '0;
              exp_n   = 1'b1;
            end else begin
              rem_n = remaining - CNT_ONE;
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          rem_n   = '0;
        end
      endcase
    end
  end

  // Channel registers; reset drops the channel silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      remaining    <= '0;
      expire_pulse <= 1'b0;
    end else begin
      state_q      <= state_n;
      remaining    <= rem_n;
      expire_pulse <= exp_n;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: rtl/powerup_timer_bank.sv
// Multi-channel power-up duration timer. A single free-running prescaler
// produces a tick every PRESCALER+1 clocks; every channel counts down on
// that shared tick. The prescaler is never restarted by a grant, so a
// grant of N ticks lasts between (N-1)*(PRESCALER+1)+1 and N*(PRESCALER+1)
// clocks depending on the prescaler phase at grant time.
//
// Grant interface: grant is a valid-only strobe with no ready; a grant is
// always accepted on the rising edge where grant is high, provided
// grant_ch addresses an existing channel and grant_time is non-zero.
// Anything else is dropped without side effects. At most one grant per cycle.
module powerup_timer_bank
  import powerup_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int CNT_W       = 4,
  parameter int PRESCALER   = DEF_PRESCALER,
  parameter int TICK_W      = 26,
  parameter int EXTEND_MODE = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    grant,
  input  logic [CH_W-1:0]         grant_ch,
  input  logic [CNT_W-1:0]        grant_time,
  input  logic                    clear_all,
  input  logic                    pause,
  output logic [NUM_CH-1:0]       active,
  output logic [NUM_CH*CNT_W-1:0] remaining,
  output logic [NUM_CH-1:0]       expire_pulse
);

  localparam logic [TICK_W-1:0] PRESC_MAX = TICK_W'(PRESCALER);
  localparam logic [CH_W:0]     CH_LIMIT  = (CH_W + 1)'(NUM_CH);

  logic [TICK_W-1:0] presc_q;
  logic              tick;
  logic              grant_ok;
  logic [NUM_CH-1:0] load_en;
  logic [0:0]        ch_state [NUM_CH];

  // Tick fires on the terminal prescaler count unless paused.
  assign tick = (presc_q == PRESC_MAX) && !pause;

  // Shared prescaler: counts 0..PRESCALER, holds while paused, ignores clear_all.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else if (!pause) begin
      if (presc_q == PRESC_MAX) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + TICK_W'(1);
      end
    end
  end

  // A grant is usable only for an existing channel and a non-zero duration.
  always_comb begin
    grant_ok = grant && ({1'b0, grant_ch} < CH_LIMIT) && (grant_time != '0);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Per-channel load strobe decoded from the shared grant bus.
    assign load_en[i] = grant_ok && (grant_ch == CH_W'(i));

    powerup_channel #(
      .CNT_W       (CNT_W),
      .EXTEND_MODE (EXTEND_MODE)
    ) u_channel (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .clear        (clear_all),
      .load_en      (load_en[i]),
      .load_val     (grant_time),
      .state_dbg    (ch_state[i]),
      .remaining    (remaining[i*CNT_W +: CNT_W]),
      .expire_pulse (expire_pulse[i])
    );

    // active is the registered RUN state of the channel.
    assign active[i] = (ch_state[i] == ST_RUN);
  end

endmodule

// File: tb/tb_powerup_timer_bank.sv
// Bench for powerup_timer_bank. Two instances (restart and extend mode)
// share one stimulus stream; a per-channel "ticks left" model derived from
// the behavioural rules predicts every output each clock.
module tb_powerup_timer_bank;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 3;
  localparam int CNT_W  = 4;
  localparam int PRE    = 3;
  localparam int MAXV   = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             grant = 1'b0;
  logic [CH_W-1:0]  grant_ch = '0;
  logic [CNT_W-1:0] grant_time = '0;
  logic             clear_all = 1'b0;
  logic             pause = 1'b0;

  logic [NUM_CH-1:0]       act0, act1, exp0, exp1;
  logic [NUM_CH*CNT_W-1:0] rem0, rem1;

  powerup_timer_bank #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W),
    .PRESCALER(PRE), .TICK_W(2), .EXTEND_MODE(0)
  ) dut_restart (
    .clk(clk), .reset(reset), .grant(grant), .grant_ch(grant_ch),
    .grant_time(grant_time), .clear_all(clear_all), .pause(pause),
    .active(act0), .remaining(rem0), .expire_pulse(exp0)
  );

  powerup_timer_bank #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W),
    .PRESCALER(PRE), .TICK_W(2), .EXTEND_MODE(1)
  ) dut_extend (
    .clk(clk), .reset(reset), .grant(grant), .grant_ch(grant_ch),
    .grant_time(grant_time), .clear_all(clear_all), .pause(pause),
    .active(act1), .remaining(rem1), .expire_pulse(exp1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // rem_m = ticks still to elapse (0 means idle); pc_m = clocks into the tick period.
  int rem_m [2][NUM_CH];
  bit exp_m [2][NUM_CH];
  int pc_m;

  task automatic model_reset();
    pc_m = 0;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NUM_CH; c++) begin
        rem_m[d][c] = 0;
        exp_m[d][c] = 1'b0;
      end
  endtask

  task automatic model_step();
    bit tk;
    tk = (pc_m == PRE) && !pause;
    if (!pause) pc_m = (pc_m + 1) % (PRE + 1);
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NUM_CH; c++) begin
        exp_m[d][c] = 1'b0;
        if (clear_all) rem_m[d][c] = 0;
        else if (grant && int'(grant_ch) == c && grant_time != 0) begin
          if (d == 1) rem_m[d][c] = (rem_m[d][c] + int'(grant_time) > MAXV) ? MAXV
                                    : rem_m[d][c] + int'(grant_time);
          else rem_m[d][c] = int'(grant_time);
        end else if (tk && rem_m[d][c] > 0) begin
          rem_m[d][c] = rem_m[d][c] - 1;
          if (rem_m[d][c] == 0) exp_m[d][c] = 1'b1;
        end
      end
  endtask

  task automatic check_all(input string tag);
    logic [NUM_CH-1:0]       ea, ee;
    logic [NUM_CH*CNT_W-1:0] er;
    for (int d = 0; d < 2; d++) begin
      ea = '0; ee = '0; er = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        ea[c] = (rem_m[d][c] != 0);
        ee[c] = exp_m[d][c];
        er[c*CNT_W +: CNT_W] = 4'(rem_m[d][c]);
      end
      check_val($sformatf("%s_active_m%0d", tag, d), 32'(d == 0 ? act0 : act1), 32'(ea));
      check_val($sformatf("%s_remaining_m%0d", tag, d), 32'(d == 0 ? rem0 : rem1), 32'(er));
      check_val($sformatf("%s_expire_m%0d", tag, d), 32'(d == 0 ? exp0 : exp1), 32'(ee));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    grant = 1'b0; grant_ch = '0; grant_time = '0; clear_all = 1'b0;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic do_grant(input int ch, input int t, input string tag);
    grant = 1'b1; grant_ch = CH_W'(ch); grant_time = CNT_W'(t);
    cycle(tag);
    set_idle();
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  // Reset asserted between edges: outputs must clear without waiting for clk.
  task automatic do_reset_mid(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    model_reset();
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // Reset mid-countdown on channel 2.
    do_grant(2, 3, "ch2_arm");
    idle_cycles(2, "ch2_run");
    do_reset_mid("rst_mid");
    idle_cycles(12, "post_rst");

    // Basic countdown and expiry on channel 1.
    do_grant(1, 2, "ch1_arm");
    check_val("ch1_rem_after_grant", 32'(rem0[1*CNT_W +: CNT_W]), 32'd2);
    check_val("ch1_active_after_grant", 32'(act0[1]), 32'd1);
    idle_cycles(12, "ch1_run");

    // Extension versus restart on channel 0 (no tick between the two grants).
    clear_all = 1'b1; cycle("clr0"); set_idle();
    do_reset_mid("rst_align");
    do_grant(0, 12, "ch0_arm12");
    do_grant(0, 9, "ch0_regrant9");
    check_val("ext_saturate", 32'(rem1[0 +: CNT_W]), 32'd15);
    check_val("restart_value", 32'(rem0[0 +: CNT_W]), 32'd9);

    // Grant colliding with the final tick on channel 3.
    clear_all = 1'b1; cycle("clr1"); set_idle();
    do_grant(3, 2, "ch3_arm");
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pc_m == PRE && rem_m[0][3] == 1) found = 1'b1;
      else cycle("ch3_wait");
    end
    check_val("ch3_align_found", 32'(found), 32'd1);
    if (found) begin
      do_grant(3, 5, "ch3_collide");
      check_val("collide_restart_rem", 32'(rem0[3*CNT_W +: CNT_W]), 32'd5);
      check_val("collide_extend_rem", 32'(rem1[3*CNT_W +: CNT_W]), 32'd6);
      check_val("collide_no_pulse", 32'({exp1[3], exp0[3]}), 32'd0);
      check_val("collide_active", 32'({act1[3], act0[3]}), 32'd3);
    end
    idle_cycles(4, "ch3_after");

    // clear_all beats a simultaneous grant.
    do_grant(0, 7, "clr_arm0");
    do_grant(2, 6, "clr_arm2");
    clear_all = 1'b1; grant = 1'b1; grant_ch = 3'd1; grant_time = 4'd4;
    cycle("clear_vs_grant");
    set_idle();
    check_val("clear_active", 32'({act1, act0}), 32'd0);
    check_val("clear_remaining", 32'({rem1, rem0}), 32'd0);
    idle_cycles(6, "after_clear");

    // Pause freezes countdown and prescaler.
    do_grant(0, 4, "pause_arm");
    pause = 1'b1;
    idle_cycles(20, "paused");
    check_val("pause_hold", 32'(rem0[0 +: CNT_W]), 32'd4);
    pause = 1'b0;
    idle_cycles(6, "unpaused");

    // Ignored grants: zero duration and out-of-range channel.
    do_grant(1, 0, "zero_time");
    do_grant(5, 7, "bad_ch");
    check_val("bad_ch_no_arm", 32'(act0[1]), 32'(rem_m[0][1] != 0));
    idle_cycles(20, "drain");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      set_idle();
      if ($urandom_range(0, 2) == 0) begin
        grant = 1'b1;
        grant_ch = CH_W'($urandom_range(0, 5));
        grant_time = CNT_W'($urandom_range(0, 15));
      end
      clear_all = ($urandom_range(0, 39) == 0);
      pause = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) begin
        set_idle();
        do_reset_mid("rand_rst");
      end else begin
        cycle("rand");
      end
    end
    set_idle();
    pause = 1'b0;
    idle_cycles(4, "tail");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
